// File: rtl/mem_bus_arbiter.sv
// Two-port memory bus arbiter: an instruction-fetch port and a data port share one
// strobed memory bus. Round-robin on contention, fixed WAIT_CYC strobe length per access.
module mem_bus_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  // instruction-fetch port (read only)
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_adr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  // data port
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_adr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  // memory bus
  output logic [ADDR_W-1:0] adr_bus,
  output logic [DATA_W-1:0] data_out,
  input  logic [DATA_W-1:0] data_in,
  output logic              rd_mem,
  output logic              wr_mem,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYC - 1);

  state_t            state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic              last_dm_q, last_dm_d;    // last grant: 0 = fetch port, 1 = data port
  logic              grant_dm_q, grant_dm_d;  // port owning the current access
  logic              we_q, we_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic any_req;
  logic pick_dm;
  logic last_access;

  assign any_req     = if_req | dm_req;
  // On contention the port that did not win last time takes the bus.
  assign pick_dm     = dm_req & (~if_req | ~last_dm_q);
  assign last_access = (state_q == ACCESS) && (wait_cnt_q == LAST_CNT);

  // State and datapath registers
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in sequential blocks keep every flop sampling
    // pre-edge values, so register order inside the block never matters.
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      last_dm_q  <= 1'b0;
      grant_dm_q <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      last_dm_q  <= last_dm_d;
      grant_dm_q <= grant_dm_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  if (last_access) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant latching, wait counting and read-data capture
  always_comb begin
    wait_cnt_d = '0;
    last_dm_d  = last_dm_q;
    grant_dm_d = grant_dm_q;
    we_d       = we_q;
    adr_d      = adr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;

    if (state_q == ACCESS && !last_access) wait_cnt_d = wait_cnt_q + 4'd1;

    if (state_q == IDLE && any_req) begin
      grant_dm_d = pick_dm;
      last_dm_d  = pick_dm;
      we_d       = pick_dm & dm_we;
      adr_d      = pick_dm ? dm_adr : if_adr;
      if (pick_dm) wdata_d = dm_wdata;
    end

    if (last_access && !we_q) begin
      if (grant_dm_q) dm_rdata_d = data_in;
      else            if_rdata_d = data_in;
    end
  end

  // Outputs decoded from the current state
  always_comb begin
    busy   = (state_q != IDLE);
    rd_mem = (state_q == ACCESS) & ~we_q;
    wr_mem = (state_q == ACCESS) &  we_q;
    if_ack = (state_q == DONE) & ~grant_dm_q;
    dm_ack = (state_q == DONE) &  grant_dm_q;
  end

  assign adr_bus  = adr_q;
  assign data_out = wdata_q;
  assign if_rdata = if_rdata_q;
  assign dm_rdata = dm_rdata_q;

endmodule
